// File: rtl/cop_pkg.sv
// Shared definitions for the coprocessor initiator: FSM states, opcode encodings,
// the default watchdog limit and the value reported on a timeout abort.
package cop_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_OP = 3'd1,
        SEND_A  = 3'd2,
        SEND_B  = 3'd3,
        WAIT    = 3'd4,
        RESP    = 3'd5
    } cop_state_e;

    localparam logic OP_GCD = 1'b0;
    localparam logic OP_LCM = 1'b1;

    localparam int                 COP_TIMEOUT_DEFAULT = 255;
    localparam logic [DATA_W-1:0]  COP_ERR_DATA        = 32'hFFFF_FFFF;

endpackage

// File: rtl/cop_watchdog.sv
// WAIT-phase cycle counter; expired is raised during the TIMEOUT_CYCLES-th enabled cycle.
// Only instantiated when COP_TIMEOUT_EN is defined.
module cop_watchdog
    import cop_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = COP_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count;

    // The counter saturates at its terminal value; the FSM leaves WAIT on that cycle anyway.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cop_initiator.sv
// Core-side initiator: sends a 3-word command burst (op, A, B) to the GCD/LCM coprocessor,
// waits for CopDone and holds the result for the core. Optional watchdog: COP_TIMEOUT_EN.
module cop_initiator
    import cop_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = COP_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              req_ready,
    output logic              Start,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData,
    input  logic              CopDone,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    cop_state_e        state;
    cop_state_e        state_nxt;
    logic              op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              accept;
    logic              capture;
    logic              abort;
    logic              wd_expired;

`ifdef COP_TIMEOUT_EN
    cop_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != WAIT),
        .enable  (state == WAIT),
        .expired (wd_expired)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are pure state decodes, so an asynchronous reset clears Start/WriteData at once.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        Start     = 1'b0;
        WriteData = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = SEND_OP;
                end
            end
            SEND_OP: begin
                Start     = 1'b1;
                WriteData = {{(DATA_W-1){1'b0}}, op_q};
                state_nxt = SEND_A;
            end
            SEND_A: begin
                Start     = 1'b1;
                WriteData = a_q;
                state_nxt = SEND_B;
            end
            SEND_B: begin
                Start     = 1'b1;
                WriteData = b_q;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A real result beats a watchdog expiry in the same cycle.
                if (CopDone) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (wd_expired) begin
                    abort     = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers only matter while their SEND state is active, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_data <= '0;
        end else if (capture) begin
            rsp_data <= ReadData;
        end else if (abort) begin
            rsp_data <= COP_ERR_DATA;
        end
    end

`ifdef COP_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_err <= 1'b0;
        end else if (capture) begin
            rsp_err <= 1'b0;
        end else if (abort) begin
            rsp_err <= 1'b1;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_cop_initiator.sv
// Self-checking bench for cop_initiator; the bench plays the GCD/LCM coprocessor and
// checks every transaction against a math-level reference.
module tb_cop_initiator;

    localparam int TB_TO = 8;
`ifdef COP_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_ready;
    logic        Start;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        CopDone;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rsp;

    cop_initiator #(
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .Start     (Start),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .CopDone   (CopDone),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    function automatic logic [31:0] gcd32(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [31:0] cop_ref(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] g;
        g = gcd32(a, b);
        if (!op) return g;
        return (a / g) * b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; done_at = WAIT cycle carrying CopDone (0 = never), hold = rsp_ready-low cycles.
    task automatic txn(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input int done_at, input int hold, input bit spur);
        logic [31:0] words [3];
        logic [31:0] exp_data;
        logic [31:0] exp_word;
        logic        exp_err;
        int          n;
        chk("idle_req_ready", req_ready, 1);
        chk("idle_start", Start, 0);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_word = (i == 0) ? {31'b0, op} : (i == 1) ? a : b;
            chk("burst_start", Start, 1);
            chk("burst_wdata", WriteData, exp_word);
            chk("burst_req_ready", req_ready, 0);
            words[i]  = WriteData;
            req_valid = 1'($urandom);
            req_op    = 1'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            CopDone   = spur && (i != 0);
            ReadData  = $urandom;
            tick();
        end
        req_valid = 1'b0;
        CopDone   = 1'b0;
        n         = 0;
        exp_err   = 1'b0;
        exp_data  = last_rsp;
        forever begin
            n++;
            chk("wait_start", Start, 0);
            chk("wait_wdata", WriteData, 0);
            chk("wait_rsp_valid", rsp_valid, 0);
            chk("wait_rsp_hold", rsp_data, last_rsp);
            if (n == done_at) begin
                CopDone  = 1'b1;
                ReadData = cop_ref(words[0][0], words[1], words[2]);
            end
            tick();
            CopDone  = 1'b0;
            ReadData = $urandom;
            if (n == done_at) begin
                exp_data = cop_ref(op, a, b);
                break;
            end
            if (TO_EN && n == TB_TO) begin
                exp_data = 32'hFFFF_FFFF;
                exp_err  = 1'b1;
                break;
            end
            if (n > 200) begin
                chk("wait_bound", 32'(n), 0);
                break;
            end
        end
        rsp_ready = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", rsp_valid, 1);
            chk("resp_data", rsp_data, exp_data);
            chk("resp_err", rsp_err, exp_err);
            chk("resp_req_ready", req_ready, 0);
            if (h == hold) rsp_ready = 1'b1;
            else begin
                CopDone  = 1'($urandom);
                ReadData = $urandom;
            end
            tick();
            CopDone = 1'b0;
        end
        rsp_ready = 1'b0;
        chk("post_req_ready", req_ready, 1);
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_rsp_hold", rsp_data, exp_data);
        last_rsp = exp_data;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_a     = '0;
        req_b     = '0;
        ReadData  = '0;
        CopDone   = 1'b0;
        rsp_ready = 1'b0;
        last_rsp  = '0;
        tick();
        tick();
        chk("rst_start", Start, 0);
        chk("rst_wdata", WriteData, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        reset_n = 1'b1;
        tick();
        chk("rst_req_ready", req_ready, 1);

        // GCD(48,18) with CopDone on WAIT cycle 4
        txn(1'b0, 32'd48, 32'd18, 4, 0, 1'b0);
        // LCM(4,6) with the core stalling 5 cycles
        txn(1'b1, 32'd4, 32'd6, 2, 5, 1'b0);

        // CopDone in IDLE is ignored, then stray pulses in SEND_A/SEND_B are ignored
        CopDone  = 1'b1;
        ReadData = 32'hBAD0_0001;
        tick();
        CopDone = 1'b0;
        chk("idle_pulse_data", rsp_data, last_rsp);
        chk("idle_pulse_ready", req_ready, 1);
        txn(1'b0, 32'd14, 32'd21, 1, 1, 1'b1);

        // reset during SEND_A
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_a     = 32'd100;
        req_b     = 32'd7;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_rst_start", Start, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_start", Start, 0);
        chk("mid_rst_wdata", WriteData, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        tick();
        reset_n  = 1'b1;
        last_rsp = '0;
        tick();
        chk("post_rst_ready", req_ready, 1);
        txn(1'b0, 32'd9, 32'd3, 3, 0, 1'b0);

`ifdef COP_TIMEOUT_EN
        txn(1'b0, 32'd12, 32'd8, 0, 1, 1'b0);
        txn(1'b1, 32'd3, 32'd5, TB_TO, 0, 1'b0);
        txn(1'b0, 32'd27, 32'd18, 0, 0, 1'b0);
`endif

        for (int k = 0; k < 20; k++) begin
            txn(1'($urandom), 32'($urandom_range(1, 2000)), 32'($urandom_range(1, 2000)),
                int'($urandom_range(1, 7)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cop_initiator.md
COP_INITIATOR -- requirements
Module: cop_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max WAIT cycles before abort (used only with COP_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  core presents an operation.
REQ-005 req_op  input  1  0 = GCD, 1 = LCM.
REQ-006 req_a  input  32  operand A, unsigned.
REQ-007 req_b  input  32  operand B, unsigned.
REQ-008 req_ready  output  1  initiator can accept a request.
REQ-009 Start  output  1  to coprocessor; high during the command burst.
REQ-010 WriteData  output  32  to coprocessor; burst word.
REQ-011 ReadData  input  32  result from coprocessor.
REQ-012 CopDone  input  1  coprocessor single-cycle pulse; ReadData valid that cycle.
REQ-013 rsp_valid  output  1  result held for core.
REQ-014 rsp_ready  input  1  core accepts result.
REQ-015 rsp_data  output  32  captured result.
REQ-016 rsp_err  output  1  result is a timeout abort.

Function
REQ-017 FSM states SHALL be IDLE, SEND_OP, SEND_A, SEND_B, WAIT, RESP.
REQ-018 req_ready SHALL equal (state == IDLE); request accepted on an edge with req_valid && req_ready; op/A/B registered at acceptance.
REQ-019 IDLE -> SEND_OP on acceptance; SEND_OP -> SEND_A -> SEND_B -> WAIT unconditionally, one cycle each.
REQ-020 Start SHALL be high exactly in SEND_OP, SEND_A, SEND_B (3 consecutive cycles, beginning the cycle after acceptance), low otherwise.
REQ-021 WriteData SHALL be {31'b0, op} in SEND_OP, A in SEND_A, B in SEND_B, 32'h0 otherwise.
REQ-022 In WAIT, CopDone high SHALL capture ReadData into rsp_data and move to RESP.
REQ-023 CopDone outside WAIT SHALL be ignored (no capture, no state change).
REQ-024 RESP: rsp_valid high, rsp_data/rsp_err stable until rsp_ready; rsp_valid && rsp_ready -> IDLE; req_ready high the following cycle.
REQ-025 rsp_data SHALL hold its last value after RESP until the next capture; rsp_valid low outside RESP.
REQ-026 req_valid while not IDLE SHALL be ignored (no queueing).
REQ-027 CopDone in the SEND_B->WAIT transition cycle does not count; only cycles in WAIT capture.

Reset
REQ-028 reset_n low SHALL immediately force IDLE; Start=0, WriteData=0, rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=1 after release, watchdog count=0.
REQ-029 Reset mid-burst or mid-WAIT SHALL drop Start the same instant; no partial result delivered.

Configuration
REQ-030 With COP_TIMEOUT_EN defined: watchdog counts WAIT cycles from 0; on count reaching TIMEOUT_CYCLES without CopDone -> RESP with rsp_data=32'hFFFFFFFF, rsp_err=1; CopDone in the same cycle wins (normal capture, rsp_err=0).
REQ-031 Without COP_TIMEOUT_EN: no watchdog logic, WAIT waits indefinitely, rsp_err tied 0.

Structure
REQ-032 Package cop_pkg SHALL hold: state enum, OP_GCD/OP_LCM encodings, default TIMEOUT_CYCLES, error value 32'hFFFFFFFF.
REQ-033 Watchdog SHALL be sub-module cop_watchdog (clear, enable, expired), instantiated only under COP_TIMEOUT_EN.

Verification
REQ-034 Req op=0 A=48 B=18; CopDone with ReadData=6 at WAIT cycle 4 -> Start high 3 cycles, WriteData 0,48,18; rsp_data=6, rsp_err=0.
REQ-035 Req op=1 A=4 B=6, rsp_ready held low 5 cycles -> rsp_valid and rsp_data=12 stable all 5 cycles; req_ready 1 cycle after handshake.
REQ-036 CopDone pulses during SEND_A and in IDLE -> ignored; only WAIT pulse with ReadData=7 captured.
REQ-037 COP_TIMEOUT_EN, TIMEOUT_CYCLES=8, no CopDone -> RESP after 8 WAIT cycles, rsp_data=32'hFFFFFFFF, rsp_err=1; CopDone at cycle 8 -> normal capture.
REQ-038 reset_n low during SEND_A -> Start and WriteData 0 immediately; after release req_ready=1, new request A=9 B=3 completes with rsp_data=3.
